// File: rtl/sb_pkg.sv
// Shared types and size encodings for the store buffer slice.
package sb_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  mask;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Memory-side write handshake of the store buffer.
interface store_buffer_if;
  logic        MemWrite;
  logic        MemReady;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemByteMask;

  modport master (
    output MemWrite, MemAddr, MemWData, MemByteMask,
    input  MemReady
  );

  modport slave (
    input  MemWrite, MemAddr, MemWData, MemByteMask,
    output MemReady
  );
endinterface

// File: rtl/store_buffer_mask_gen.sv
// Byte-enable generation from access size and low address bits.
module store_mask_gen
  import sb_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask
);

  // Halfword bit is tested first so it wins over the byte flag.
  always_comb begin
    mask = 4'b1111;
    if (size[1]) begin
      mask = addr_lo[1] ? 4'b1100 : 4'b0011;
    end else if (size == SZ_BYTE) begin
      mask = 4'b0001 << addr_lo;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the memory stage and the data memory port,
// with a conservative word-address load hazard check.
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          StoreM,
  input  logic          ByteorWord,
  input  logic          Halfword,
  input  logic [31:0]   AddrM,
  input  logic [31:0]   WriteDataM,
  input  logic          LoadM,
  input  logic [31:0]   LoadAddrM,
  output logic          StallSB,
  output logic          Empty,
  store_buffer_if.master mem
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic [DEPTH-1:0] valid;
  sb_entry_t     entries [DEPTH];

  logic [3:0] new_mask;
  logic       full, enq, deq, hazard;
  sb_entry_t  head_e;

  store_mask_gen u_mask (
    .size    ({Halfword, ByteorWord}),
    .addr_lo (AddrM[1:0]),
    .mask    (new_mask)
  );

  assign full  = (count == FULL_CNT);
  assign Empty = (count == '0);
  assign enq   = StoreM && !full;
  assign deq   = mem.MemWrite && mem.MemReady;

  assign head_e          = entries[head];
  assign mem.MemWrite    = !Empty;
  assign mem.MemAddr     = mem.MemWrite ? {head_e.waddr, 2'b00} : '0;
  assign mem.MemWData    = mem.MemWrite ? head_e.data : '0;
  assign mem.MemByteMask = mem.MemWrite ? head_e.mask : '0;

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[PW'(i)] && entries[PW'(i)].waddr == LoadAddrM[31:2]) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard && LoadM;
  end

  assign StallSB = (StoreM && full) || hazard;

  // Enqueue is blocked when full, so tail never equals head on a same-cycle
  // enqueue/dequeue and the two valid-bit updates cannot collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (enq) begin
        tail        <= tail + 1'b1;
        valid[tail] <= 1'b1;
      end
      if (deq) begin
        head        <= head + 1'b1;
        valid[head] <= 1'b0;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      entries[tail] <= '{waddr: AddrM[31:2], mask: new_mask, data: WriteDataM};
    end
  end

endmodule
